// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART TX sequencer and its bus helper.
package uart_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POLL  = 2'd1,
        WRITE = 2'd2,
        NEXT  = 2'd3
    } seq_state_e;

    localparam logic [3:0] UART_TX_OFS = 4'h0;
    localparam logic [3:0] UART_RX_OFS = 4'h4;
    localparam int         TX_FULL_BIT = 0;
    localparam logic [3:0] WSTRB_READ  = 4'h0;
    localparam logic [3:0] WSTRB_WRITE = 4'hF;

    // Requested byte count: 1..3 are taken as-is, anything else means a whole word.
    function automatic logic [2:0] eff_len(input logic [2:0] len);
        logic [2:0] res;
        case (len)
            3'd1, 3'd2, 3'd3: res = len;
            default:          res = 3'd4;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_bus_xact.sv
// Single-transaction bus master: one status read or one byte write per start.
// m_valid/m_wstrb/m_wdata are registered and held stable until m_ready.
module uart_bus_xact
    import uart_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        wr,
    input  logic [7:0]  data,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        m_valid,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    output logic        done,
    output logic [31:0] rdata
);

    logic        r_valid;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;

    // Launch a transaction on start, retire it on the cycle m_ready is sampled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_wstrb <= WSTRB_READ;
            r_wdata <= 32'h0000_0000;
        end else if (r_valid && m_ready) begin
            r_valid <= 1'b0;
            r_wstrb <= WSTRB_READ;
            r_wdata <= 32'h0000_0000;
        end else if (start && !r_valid) begin
            r_valid <= 1'b1;
            r_wstrb <= wr ? WSTRB_WRITE : WSTRB_READ;
            r_wdata <= wr ? {24'h00_0000, data} : 32'h0000_0000;
        end else begin
            r_valid <= r_valid;
            r_wstrb <= r_wstrb;
            r_wdata <= r_wdata;
        end
    end

    assign m_valid = r_valid;
    assign m_wstrb = r_wstrb;
    assign m_wdata = r_wdata;
    assign done    = r_valid && m_ready;
    assign rdata   = m_rdata;

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART TX sequencer: sends 1..4 bytes of a word LSB first, polling the
// UART tx_full status before every byte write.
// Optional feature macro: UART_SEQ_TIMEOUT_EN (per-byte poll limit + sticky err).
module uart_tx_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter int          POLL_LIMIT = 1024
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_len,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        m_cs,
    output logic        busy
`ifdef UART_SEQ_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    seq_state_e  r_state;
    seq_state_e  w_state_next;
    logic [31:0] r_data;
    logic [2:0]  r_len;
    logic [1:0]  r_idx;
    logic        r_req_ready;
    logic        r_busy;
    logic        w_start;
    logic        w_wr;
    logic        w_done;
    logic        w_last;
    logic [7:0]  w_byte;
    logic [31:0] w_rdata;

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_LIMIT + 1);
    logic [CNT_W-1:0] r_poll_cnt;
    logic             r_err;
    logic             w_limit;
    logic             w_abort;

    assign w_limit = (r_poll_cnt == CNT_W'(POLL_LIMIT - 1));
`endif

    // Index 0..3 never needs to reach 4, so compare index+1 against the length.
    assign w_last = (({1'b0, r_idx} + 3'd1) == r_len);

    // Byte currently being sent: the latched word shifted down by 8*index.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            2'd3:    w_byte = r_data[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    // Next-state and transaction-launch logic; polls start together with
    // entering POLL, writes start one cycle after entering WRITE (bus gap).
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_wr         = 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_state_next = POLL;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            POLL: begin
                if (w_done) begin
                    if (w_rdata[TX_FULL_BIT]) begin
`ifdef UART_SEQ_TIMEOUT_EN
                        if (w_limit) begin
                            w_state_next = IDLE;
                            w_abort      = 1'b1;
                        end else begin
                            w_state_next = POLL;
                        end
`else
                        w_state_next = POLL;
`endif
                    end else begin
                        w_state_next = WRITE;
                    end
                end else if (!m_valid) begin
                    w_start = 1'b1;
                end else begin
                    w_start = 1'b0;
                end
            end
            WRITE: begin
                if (w_done) begin
                    w_state_next = NEXT;
                end else if (!m_valid) begin
                    w_start = 1'b1;
                    w_wr    = 1'b1;
                end else begin
                    w_start = 1'b0;
                end
            end
            NEXT: begin
                if (w_last) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = POLL;
                    w_start      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == IDLE);
            r_busy      <= (w_state_next != IDLE);
        end
    end

    // Latch the word and its effective length on accept; advance the byte index in NEXT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data <= 32'h0000_0000;
            r_len  <= 3'd0;
            r_idx  <= 2'd0;
        end else if (r_state == IDLE && w_state_next == POLL) begin
            r_data <= req_data;
            r_len  <= eff_len(req_len);
            r_idx  <= 2'd0;
        end else if (r_state == NEXT && !w_last) begin
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_idx  <= r_idx;
        end
    end

`ifdef UART_SEQ_TIMEOUT_EN
    // Count full status results per byte; err latches when the limit aborts a word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_poll_cnt <= {CNT_W{1'b0}};
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE || w_state_next == WRITE) begin
                r_poll_cnt <= {CNT_W{1'b0}};
            end else if (r_state == POLL && w_done && w_rdata[TX_FULL_BIT]) begin
                r_poll_cnt <= r_poll_cnt + CNT_W'(1);
            end else begin
                r_poll_cnt <= r_poll_cnt;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign err = r_err;
`endif

    uart_bus_xact u_xact (
        .clk     (clk),
        .resetn  (resetn),
        .start   (w_start),
        .wr      (w_wr),
        .data    (w_byte),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_valid (m_valid),
        .m_wstrb (m_wstrb),
        .m_wdata (m_wdata),
        .done    (w_done),
        .rdata   (w_rdata)
    );

    assign m_addr    = UART_BASE + {28'h000_0000, UART_TX_OFS};
    assign m_cs      = m_valid;
    assign req_ready = r_req_ready;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a behavioural UART slave.
// Honours UART_SEQ_TIMEOUT_EN for the timeout scenario.
module tb_uart_tx_sequencer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = 32'h0;
    logic [2:0]  req_len = 3'd0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = 32'h0;
    logic        m_cs;
    logic        busy;
`ifdef UART_SEQ_TIMEOUT_EN
    logic        err;
`endif

    int total = 0;
    int bad = 0;

    // slave model state
    int          s_delay = 0;
    int          s_full_until = 0;
    int          s_wait = 0;
    int          s_reads = 0;
    int          s_writes = 0;
    int          s_unstable = 0;
    int          s_b2b = 0;
    int          s_bad_wr = 0;
    int          s_cs_bad = 0;
    bit          s_fresh = 1'b0;
    logic [31:0] s_cap_wdata = 32'h0;
    logic [3:0]  s_cap_wstrb = 4'h0;
    logic [7:0]  wq[$];

    always #5 clk = ~clk;

    uart_tx_sequencer #(.UART_BASE(BASE), .POLL_LIMIT(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_cs      (m_cs),
        .busy      (busy)
`ifdef UART_SEQ_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    // UART slave: answers each request after s_delay extra cycles, reports
    // tx_full while the read count is below s_full_until, logs every write.
    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ready = 1'b0;
            m_rdata = 32'h0;
            s_wait  = 0;
            s_fresh = 1'b0;
        end else begin
            if (m_cs !== m_valid || (m_valid && m_addr !== BASE)) s_cs_bad++;
            if (m_ready) begin
                if (m_valid) s_b2b++;
                m_ready = 1'b0;
                m_rdata = 32'h0;
                s_wait  = 0;
            end else if (m_valid) begin
                if (s_wait == 0) begin
                    s_cap_wdata = m_wdata;
                    s_cap_wstrb = m_wstrb;
                end else if (m_wdata !== s_cap_wdata || m_wstrb !== s_cap_wstrb) begin
                    s_unstable++;
                end
                if (s_wait > s_delay) begin
                    m_ready = 1'b1;
                    if (m_wstrb === 4'h0) begin
                        m_rdata = {31'h0, (s_reads < s_full_until)};
                        s_fresh = !(s_reads < s_full_until);
                        s_reads++;
                    end else if (m_wstrb === 4'hF && m_wdata[31:8] === 24'h0) begin
                        if (!s_fresh) s_bad_wr++;
                        s_fresh = 1'b0;
                        wq.push_back(m_wdata[7:0]);
                        s_writes++;
                    end else begin
                        s_bad_wr++;
                    end
                end else begin
                    s_wait++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word, then count cycles until busy drops (bounded).
    task automatic run_word(input logic [31:0] d, input logic [2:0] len, output int cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", req_ready, 32'd1);
        req_valid = 1'b1;
        req_data  = d;
        req_len   = len;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Compare logged writes starting at base with the low n bytes of d.
    task automatic chk_writes(input string tag, input int base, input logic [31:0] d, input int n);
        logic [31:0] t;
        chk({tag, "_nwrites"}, wq.size(), base + n);
        for (int i = 0; i < n; i++) begin
            t = d >> (8 * i);
            chk({tag, "_byte"}, (base + i < wq.size()) ? {24'h0, wq[base + i]} : 32'hDEAD, {24'h0, t[7:0]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r0;
        int w0;
        int guard;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 32'd0);
        chk("rst_m_cs", m_cs, 32'd0);
        chk("rst_m_wstrb", m_wstrb, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_addr", m_addr, BASE);
        chk("rst_req_ready", req_ready, 32'd0);
        chk("rst_busy", busy, 32'd0);
`ifdef UART_SEQ_TIMEOUT_EN
        chk("rst_err", err, 32'd0);
`endif
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", req_ready, 32'd1);

        // single byte
        r0 = s_reads; w0 = wq.size();
        run_word(32'h0000_0041, 3'd1, cyc);
        chk("single_cycles", cyc, 32'd6);
        chk("single_reads", s_reads - r0, 32'd1);
        chk_writes("single", w0, 32'h0000_0041, 1);
        chk("single_req_ready", req_ready, 32'd1);

        // full word, len 0 means 4
        r0 = s_reads; w0 = wq.size();
        run_word(32'h4443_4241, 3'd0, cyc);
        chk("word_cycles", cyc, 32'd24);
        chk("word_reads", s_reads - r0, 32'd4);
        chk_writes("word", w0, 32'h4443_4241, 4);

        // three bytes
        r0 = s_reads; w0 = wq.size();
        run_word(32'hFFC3_C2C1, 3'd3, cyc);
        chk("len3_cycles", cyc, 32'd18);
        chk("len3_reads", s_reads - r0, 32'd3);
        chk_writes("len3", w0, 32'h00C3_C2C1, 3);

        // len 7 treated as 4
        w0 = wq.size();
        run_word(32'hD4D3_D2D1, 3'd7, cyc);
        chk("len7_cycles", cyc, 32'd24);
        chk_writes("len7", w0, 32'hD4D3_D2D1, 4);

        // backpressure: first 3 reads of byte 0 report full
        r0 = s_reads; w0 = wq.size();
        s_full_until = s_reads + 3;
        run_word(32'h0000_6261, 3'd2, cyc);
        chk("bp_reads", s_reads - r0, 32'd5);
        chk("bp_cycles", cyc, 32'd21);
        chk_writes("bp", w0, 32'h0000_6261, 2);

        // slow slave: 5 extra cycles on every transaction
        w0 = wq.size();
        s_delay = 5;
        run_word(32'h0000_7877, 3'd2, cyc);
        s_delay = 0;
        chk("slow_cycles", cyc, 32'd32);
        chk_writes("slow", w0, 32'h0000_7877, 2);

        // reset during the write of byte 1 (second byte)
        w0 = wq.size();
        s_delay = 3;
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'h7473_7271; req_len = 3'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        while (!(wq.size() == w0 + 1 && m_valid && m_wstrb == 4'hF) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_reached_write2", (guard < 500) ? 32'd1 : 32'd0, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 32'd0);
        chk("midrst_m_wstrb", m_wstrb, 32'd0);
        chk("midrst_m_wdata", m_wdata, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_req_ready", req_ready, 32'd0);
        s_delay = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run_word(32'h0000_5A59, 3'd2, cyc);
        chk("midrst_new_cycles", cyc, 32'd12);
        chk("midrst_old_byte", (w0 < wq.size()) ? {24'h0, wq[w0]} : 32'hDEAD, 32'h71);
        chk_writes("midrst_new", w0 + 1, 32'h0000_5A59, 2);

`ifdef UART_SEQ_TIMEOUT_EN
        // tx_full stuck: 8 reads then abort with sticky err
        r0 = s_reads; w0 = wq.size();
        s_full_until = s_reads + 1000;
        run_word(32'h0000_0099, 3'd1, cyc);
        chk("to_reads", s_reads - r0, 32'd8);
        chk("to_cycles", cyc, 32'd23);
        chk("to_err", err, 32'd1);
        chk("to_busy", busy, 32'd0);
        chk("to_nwrites", wq.size(), w0);
        s_full_until = s_reads;
        w0 = wq.size();
        run_word(32'h0000_0055, 3'd1, cyc);
        chk("to_after_cycles", cyc, 32'd6);
        chk_writes("to_after", w0, 32'h0000_0055, 1);
        chk("to_err_sticky", err, 32'd1);
`endif

        // bus protocol counters from the slave over the whole run
        chk("proto_unstable", s_unstable, 32'd0);
        chk("proto_back_to_back", s_b2b, 32'd0);
        chk("proto_write_without_poll", s_bad_wr, 32'd0);
        chk("proto_cs_addr", s_cs_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
